fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//   Parametrised instruction-fetch front end between Sysbus and the decoder. Issues line reads,
//   drops beats below the fetch offset, fills a byte ring buffer and presents a MAX_DECODE-byte
//   window plus its address to ID. Adds redirect (branch/flush), stale-line draining and
//   variable-width consume, replacing the fixed in-core fetch logic.
// PARAMETERS
//   BUF_BYTES   128  ring capacity in bytes; power of 2, >= 2*LINE_BYTES
//   LINE_BYTES  64   bytes per bus read request; power of 2
//   BEAT_BYTES  8    bytes per response beat; power of 2, divides LINE_BYTES
//   MAX_DECODE  15   window width in bytes = max instruction length
//   ADDR_W      64   address width
// PORTS
//   clk          in   1                  clock
//   reset        in   1                  asynchronous, active-low reset
//   entry        in   ADDR_W             start address, sampled while reset is asserted
//   redir_valid  in   1                  redirect fetch stream this cycle
//   redir_addr   in   ADDR_W             redirect target (any byte alignment)
//   req_valid    out  1                  line read request
//   req_addr     out  ADDR_W             line-aligned request address
//   req_ack      in   1                  bus accepted request
//   resp_valid   in   1                  response beat valid
//   resp_data    in   BEAT_BYTES*8       beat data, byte 0 in bits [7:0]
//   resp_ack     out  1                  = resp_valid (always accept)
//   win_valid    out  1                  >= MAX_DECODE bytes buffered
//   win_bytes    out  MAX_DECODE*8       window, byte k in bits [8k+7:8k]
//   win_addr     out  ADDR_W             address of win_bytes byte 0
//   consume      in   $clog2(MAX_DECODE+1) bytes retired by ID this cycle
// BEHAVIOUR
//   Reset: req_valid=0, win_valid=0, rd/wr ptr=0, stale=0, state IDLE; win_addr=entry,
//     fetch line=entry&~(LINE-1), skip_beats=entry[line offset]/BEAT, lead_skip=entry%BEAT.
//   FSM IDLE->REQ when free>=LINE_BYTES and !redir_valid; REQ holds req_valid/req_addr stable
//     until req_ack; REQ->WAIT on ack; WAIT->ACTIVE on first beat; ACTIVE->IDLE on final beat
//     (beat counter == LINE/BEAT-1). Exactly one request outstanding.
//   Beat handling (stale=0): beats with index < skip_beats discarded; first kept beat writes
//     BEAT-lead_skip bytes starting at byte lead_skip; others write BEAT bytes at wr_ptr.
//     Writes are byte-granular, modulo BUF_BYTES (may straddle wrap). skip_beats and lead_skip
//     clear after the first line. fetch line += LINE_BYTES on line completion.
//   Occupancy = wr_ptr-rd_ptr, pointers $clog2(BUF_BYTES)+1 bits; free = BUF_BYTES-occupancy.
//     Request gate counts a full line, so overflow is impossible.
//   Window: bytes rd_ptr..rd_ptr+MAX_DECODE-1 mod BUF_BYTES, combinational. win_valid is
//     combinational from occupancy; bytes beyond occupancy are don't-care.
//   Consume: rd_ptr += consume, win_addr += consume, same edge. consume>0 with win_valid=0,
//     or consume>MAX_DECODE, is a protocol error (assert).
//   Redirect (priority over consume and beat write in the same cycle): next edge rd=wr=0,
//     win_addr=redir_addr, new fetch line/skip_beats/lead_skip from redir_addr; if state!=IDLE,
//     set stale=1. REQ continues to ack; WAIT/ACTIVE continue. All beats of a stale line are
//     acked and discarded; stale clears and state goes IDLE on its final beat. The new request
//     issues no earlier than the cycle after.
//   Redirect in IDLE: no stale line; new request may assert the next cycle.
//   Back-to-back redirects: last one wins; stale stays set until the outstanding line ends.
//   Reset asserted mid-line: all state cleared asynchronously; the bus must not deliver
//     beats after reset release.
//   Latency: final beat at edge N -> win_valid visible after edge N if occupancy >= MAX_DECODE.
// STRUCTURE
//   Package cse502_fetch_pkg: fetch_state_t {IDLE,REQ,WAIT,ACTIVE}; line/beat index helper
//     functions; elaboration-time parameter legality checks.
//   Sub-module fetch_ring: byte ring with BEAT-wide unaligned write port, MAX_DECODE-wide read
//     window and pointer/occupancy logic. FSM, skip and address logic stay in fetch_queue.
// TESTING
//   1 Reset, entry=0x1000, memory byte i = i&0xFF, no consume -> one req 0x1000; after 8 beats
//     win_valid=1, win_addr=0x1000, win_bytes byte0=0x00, byte14=0x0E; second req 0x1040 only.
//   2 entry=0x1013 -> beats 0-1 dropped, first byte written=0x13; win_addr=0x1013; occupancy
//     after line=45.
//   3 consume=15 every valid cycle over 0x2000..0x2400 -> window bytes contiguous across every
//     ring wrap; win_addr steps by 15; no byte skipped or repeated.
//   4 consume=0 indefinitely -> requests stop once free<64: exactly 2 lines fetched, req_valid
//     stays 0, no overflow.
//   5 redir_addr=0x3005 during beat 3 of line 0x1040 -> beats 3-7 acked and discarded;
//     next req 0x3000; win_addr=0x3005, first byte=0x05.
//   6 Redirect same cycle as consume=7 and a live beat -> redirect wins: rd=wr=0, beat dropped,
//     win_addr=redir_addr.

Source files
------------

// File: rtl/cse502_fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
//   fetch_state_t  : line-fetch FSM state (IDLE, REQ, WAIT, ACTIVE)
//   is_pow2        : power-of-two test used by the parameter legality check
//   params_legal   : elaboration-time legality of the fetch_queue geometry
//   beat_index     : beat number of a byte address inside its line
//   beat_offset    : byte offset of an address inside its beat
package cse502_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT   = 2'd2,
    ACTIVE = 2'd3
  } fetch_state_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_legal(input int unsigned buf_bytes,
                                      input int unsigned line_bytes,
                                      input int unsigned beat_bytes,
                                      input int unsigned max_decode);
    return is_pow2(buf_bytes) && is_pow2(line_bytes) && is_pow2(beat_bytes) &&
           (beat_bytes <= line_bytes) && (buf_bytes >= 2 * line_bytes) &&
           (max_decode >= 1) && (max_decode <= buf_bytes);
  endfunction

  // addr_lo only needs the low line-offset bits of the address.
  function automatic int unsigned beat_index(input int unsigned addr_lo,
                                             input int unsigned line_bytes,
                                             input int unsigned beat_bytes);
    return (addr_lo % line_bytes) / beat_bytes;
  endfunction

  function automatic int unsigned beat_offset(input int unsigned addr_lo,
                                              input int unsigned beat_bytes);
    return addr_lo % beat_bytes;
  endfunction

endpackage

// File: rtl/fetch_ring.sv
// Byte ring buffer behind the fetch queue.
//   clk, reset    : clock, asynchronous active-low reset
//   clear         : empty the ring next edge (rd = wr = 0); wins over write/consume
//   wr_en         : write one beat this edge
//   wr_lead       : first byte of wr_data to keep; bytes [lead..BEAT-1] land at wr_ptr..
//   wr_data       : beat data, byte 0 in bits [7:0]
//   consume       : bytes to retire from the read side this edge
//   win_bytes     : MAX_DECODE bytes starting at rd_ptr (wraps modulo BUF_BYTES)
//   occupancy     : wr_ptr - rd_ptr
// Pointers carry one extra bit so a full ring (occupancy == BUF_BYTES) is distinct
// from an empty one.
module fetch_ring
  import cse502_fetch_pkg::*;
#(
  parameter int BUF_BYTES  = 128,
  parameter int BEAT_BYTES = 8,
  parameter int MAX_DECODE = 15
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  clear,
  input  logic                                  wr_en,
  input  logic [(BEAT_BYTES>1 ? $clog2(BEAT_BYTES) : 1)-1:0] wr_lead,
  input  logic [BEAT_BYTES*8-1:0]               wr_data,
  input  logic [$clog2(MAX_DECODE+1)-1:0]       consume,
  output logic [MAX_DECODE*8-1:0]               win_bytes,
  output logic [$clog2(BUF_BYTES):0]            occupancy
);

  localparam int IDX_W = $clog2(BUF_BYTES);
  localparam int PTR_W = IDX_W + 1;

  logic [7:0]       mem [BUF_BYTES];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [IDX_W-1:0] wr_idx [BEAT_BYTES];
  logic [BEAT_BYTES-1:0] wr_byte_en;

  // Byte k of the beat goes to wr_ptr + (k - lead); the IDX_W truncation makes
  // a beat that straddles the end of the ring wrap naturally.
  always_comb begin
    wr_byte_en = '0;
    for (int k = 0; k < BEAT_BYTES; k++) begin
      wr_idx[k]     = wr_ptr[IDX_W-1:0] + IDX_W'(k) - IDX_W'(wr_lead);
      wr_byte_en[k] = wr_en && (k >= int'(wr_lead));
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < BEAT_BYTES; k++) begin
      if (wr_byte_en[k]) mem[wr_idx[k]] <= wr_data[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(BEAT_BYTES) - PTR_W'(wr_lead);
      rd_ptr <= rd_ptr + PTR_W'(consume);
    end
  end

  assign occupancy = wr_ptr - rd_ptr;

  always_comb begin
    win_bytes = '0;
    for (int k = 0; k < MAX_DECODE; k++) begin
      win_bytes[8*k +: 8] = mem[rd_ptr[IDX_W-1:0] + IDX_W'(k)];
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end between the system bus and the decoder.
//   clk, reset          : clock, asynchronous active-low reset
//   entry               : start address, sampled while reset is low
//   redir_valid/addr    : redirect the fetch stream (branch/flush)
//   req_valid/addr/ack  : line read request to the bus
//   resp_valid/data/ack : response beats from the bus (always accepted)
//   win_valid/bytes/addr: MAX_DECODE-byte decode window and its address
//   consume             : bytes retired by the decoder this cycle
//   dbg_state/stale/occupancy : FSM state, stale-line flag and ring fill level
// Handshakes: a request transfers on a cycle where req_valid && req_ack; req_valid
// and req_addr hold steady until then. A beat transfers whenever resp_valid is high
// (resp_ack mirrors it). The window is consumed by a nonzero consume, which is only
// legal while win_valid is high.
module fetch_queue
  import cse502_fetch_pkg::*;
#(
  parameter int BUF_BYTES  = 128,
  parameter int LINE_BYTES = 64,
  parameter int BEAT_BYTES = 8,
  parameter int MAX_DECODE = 15,
  parameter int ADDR_W     = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ADDR_W-1:0]               entry,
  input  logic                            redir_valid,
  input  logic [ADDR_W-1:0]               redir_addr,
  output logic                            req_valid,
  output logic [ADDR_W-1:0]               req_addr,
  input  logic                            req_ack,
  input  logic                            resp_valid,
  input  logic [BEAT_BYTES*8-1:0]         resp_data,
  output logic                            resp_ack,
  output logic                            win_valid,
  output logic [MAX_DECODE*8-1:0]         win_bytes,
  output logic [ADDR_W-1:0]               win_addr,
  input  logic [$clog2(MAX_DECODE+1)-1:0] consume,
  output fetch_state_t                    dbg_state,
  output logic                            dbg_stale,
  output logic [$clog2(BUF_BYTES):0]      dbg_occupancy
);

  localparam int PTR_W  = $clog2(BUF_BYTES) + 1;
  localparam int CONS_W = $clog2(MAX_DECODE + 1);
  localparam int BEATS  = LINE_BYTES / BEAT_BYTES;
  localparam int BCW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LO_W   = (BEAT_BYTES > 1) ? $clog2(BEAT_BYTES) : 1;
  localparam int LOFF_W = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_BYTES - 1);

  if (!params_legal(BUF_BYTES, LINE_BYTES, BEAT_BYTES, MAX_DECODE)) begin : g_bad_params
    $error("fetch_queue: illegal buffer/line/beat geometry");
  end

  fetch_state_t      state;
  logic              req_valid_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [ADDR_W-1:0] fetch_line;
  logic [ADDR_W-1:0] win_addr_q;
  logic [BCW-1:0]    skip_beats;
  logic [BCW-1:0]    beat_cnt;
  logic [LO_W-1:0]   lead_skip;
  logic              stale;

  logic [PTR_W-1:0]  occupancy;
  logic [PTR_W-1:0]  free_bytes;
  logic              beat_fire;
  logic              last_beat;
  logic              line_done;
  logic              beat_keep;
  logic              line_open_next;
  logic [LO_W-1:0]   wr_lead;

  logic [ADDR_W-1:0] entry_line, redir_line;
  logic [BCW-1:0]    entry_skip, redir_skip;
  logic [LO_W-1:0]   entry_lead, redir_lead;

  assign entry_line = entry & ~LINE_MASK;
  assign entry_skip = BCW'(beat_index(32'(entry[LOFF_W-1:0]), LINE_BYTES, BEAT_BYTES));
  assign entry_lead = LO_W'(beat_offset(32'(entry[LOFF_W-1:0]), BEAT_BYTES));
  assign redir_line = redir_addr & ~LINE_MASK;
  assign redir_skip = BCW'(beat_index(32'(redir_addr[LOFF_W-1:0]), LINE_BYTES, BEAT_BYTES));
  assign redir_lead = LO_W'(beat_offset(32'(redir_addr[LOFF_W-1:0]), BEAT_BYTES));

  assign beat_fire = resp_valid && (state == WAIT || state == ACTIVE);
  assign last_beat = (beat_cnt == BCW'(BEATS - 1));
  assign line_done = beat_fire && last_beat;

  // A beat is stored only for a live line, below-offset beats are dropped, and a
  // redirect in the same cycle discards it along with everything else buffered.
  assign beat_keep = beat_fire && !stale && !redir_valid && (beat_cnt >= skip_beats);
  assign wr_lead   = (beat_cnt == skip_beats) ? lead_skip : '0;

  // Whether a bus line is still owed to us after this edge; a redirect while one
  // is owed must mark it stale so its remaining beats get thrown away.
  assign line_open_next = (state == REQ) ||
                          ((state == WAIT || state == ACTIVE) && !line_done);

  assign free_bytes = PTR_W'(BUF_BYTES) - occupancy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      fetch_line  <= entry_line;
      skip_beats  <= entry_skip;
      lead_skip   <= entry_lead;
      beat_cnt    <= '0;
      stale       <= 1'b0;
      win_addr_q  <= entry;
    end else begin
      unique case (state)
        IDLE: begin
          // A full line of space is reserved before asking, so beats never overflow.
          if (free_bytes >= PTR_W'(LINE_BYTES) && !redir_valid) begin
            state       <= REQ;
            req_valid_q <= 1'b1;
            req_addr_q  <= fetch_line;
          end
        end
        REQ: begin
          if (req_ack) begin
            state       <= WAIT;
            req_valid_q <= 1'b0;
          end
        end
        WAIT: begin
          if (resp_valid) state <= last_beat ? IDLE : ACTIVE;
        end
        ACTIVE: begin
          if (resp_valid && last_beat) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (beat_fire) beat_cnt <= last_beat ? '0 : beat_cnt + BCW'(1);

      if (line_done) begin
        if (stale) begin
          stale <= 1'b0;
        end else begin
          fetch_line <= fetch_line + ADDR_W'(LINE_BYTES);
          skip_beats <= '0;
          lead_skip  <= '0;
        end
      end

      if (redir_valid) begin
        fetch_line <= redir_line;
        skip_beats <= redir_skip;
        lead_skip  <= redir_lead;
        win_addr_q <= redir_addr;
        stale      <= line_open_next;
      end else begin
        win_addr_q <= win_addr_q + ADDR_W'(consume);
      end
    end
  end

  fetch_ring #(
    .BUF_BYTES (BUF_BYTES),
    .BEAT_BYTES(BEAT_BYTES),
    .MAX_DECODE(MAX_DECODE)
  ) u_ring (
    .clk      (clk),
    .reset    (reset),
    .clear    (redir_valid),
    .wr_en    (beat_keep),
    .wr_lead  (wr_lead),
    .wr_data  (resp_data),
    .consume  (consume),
    .win_bytes(win_bytes),
    .occupancy(occupancy)
  );

  assign req_valid     = req_valid_q;
  assign req_addr      = req_addr_q;
  assign resp_ack      = resp_valid;
  assign win_valid     = (occupancy >= PTR_W'(MAX_DECODE));
  assign win_addr      = win_addr_q;
  assign dbg_state     = state;
  assign dbg_stale     = stale;
  assign dbg_occupancy = occupancy;

  a_consume_needs_window : assert property (
    @(posedge clk) disable iff (!reset) (consume != '0) |-> win_valid);
  a_consume_in_range : assert property (
    @(posedge clk) disable iff (!reset) consume <= CONS_W'(MAX_DECODE));

endmodule
